// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Start bit appears the cycle after acceptance; requests while busy are dropped, so the caller must hold or re-assert data_valid.
module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [PRESCALE_WIDTH-1:0] period_q;
  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          next_idx;
  logic                      slot_end;
  logic                      par_bit;

  assign slot_end = (cnt == period_q - PRESCALE_WIDTH'(1));
  assign next_idx = bit_idx + IDX_W'(1);
  // Odd parity is the inverse of the even (XOR-reduce) bit.
  assign par_bit  = par_typ_q ^ (^data_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      period_q  <= '0;
    end else if (state == IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      if (data_valid) begin
        data_q    <= p_data;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        // A zero prescale would never reach the end of a slot, so run it as one cycle.
        period_q  <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
        state     <= START;
        tx_out    <= 1'b0;
        busy      <= 1'b1;
      end
    end else if (!slot_end) begin
      cnt <= cnt + PRESCALE_WIDTH'(1);
    end else begin
      cnt <= '0;
      case (state)
        START: begin
          state  <= DATA;
          tx_out <= data_q[0];
        end
        DATA: begin
          if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            bit_idx <= '0;
            if (par_en_q) begin
              state  <= PARITY;
              tx_out <= par_bit;
            end else begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
          end else begin
            bit_idx <= next_idx;
            tx_out  <= data_q[next_idx];
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          tx_out <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised scoreboard bench for uart_tx_frame: a frame-level model predicts each
// accepted frame (bit list, bit period, start cycle); a monitor checks the line cycle by cycle.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd0;
  logic       tx_out;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .prescale  (prescale),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          p;
    int          start;
  } frame_t;

  frame_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     free_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Frame as the line should carry it: start 0, data LSB first, parity, stop 1.
  function automatic frame_t make_frame(input logic [7:0] d, input logic pen,
                                        input logic ptyp, input logic [5:0] pre, input int st);
    frame_t f;
    int ones;
    f.bits  = '0;
    f.nbits = 0;
    ones    = 0;
    f.bits[f.nbits] = 1'b0;
    f.nbits++;
    for (int i = 0; i < 8; i++) begin
      f.bits[f.nbits] = d[i];
      if (d[i]) ones++;
      f.nbits++;
    end
    if (pen) begin
      // even: 1 when the count of ones is odd; odd: the inverse
      f.bits[f.nbits] = ((ones % 2) == 1) ^ ptyp;
      f.nbits++;
    end
    f.bits[f.nbits] = 1'b1;
    f.nbits++;
    f.p     = (pre == 6'd0) ? 1 : int'(pre);
    f.start = st;
    return f;
  endfunction

  // Reference model: a request is taken once the previous frame plus one idle cycle is over.
  always @(posedge clk) begin
    frame_t f;
    cyc++;
    if (rst) begin
      exp_q.delete();
      free_cyc = cyc + 1;
    end else if (data_valid && cyc >= free_cyc) begin
      f = make_frame(p_data, par_en, par_typ, prescale, cyc);
      exp_q.push_back(f);
      free_cyc = cyc + f.nbits * f.p + 1;
    end
  end

  frame_t cur;
  bit     in_frame = 1'b0;
  bit     spurious = 1'b0;
  int     k = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      spurious = 1'b0;
      check("rst_tx_out", 32'(tx_out), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end else begin
      if (!in_frame && !spurious && busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_frame");
          spurious = 1'b1;
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          k        = 0;
          check("frame_start_cycle", 32'(cyc), 32'(cur.start));
        end
      end
      if (in_frame) begin
        check("busy_in_frame", 32'(busy), 32'd1);
        check("tx_bit", 32'(tx_out), 32'(cur.bits[k / cur.p]));
        k++;
        if (k == cur.nbits * cur.p) in_frame = 1'b0;
      end else if (spurious) begin
        if (busy === 1'b0) spurious = 1'b0;
      end else begin
        check("idle_tx_out", 32'(tx_out), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] pre);
    p_data     = d;
    par_en     = pen;
    par_typ    = ptyp;
    prescale   = pre;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    // scramble inputs so only latched values can produce the right frame
    p_data     = 8'($urandom);
    par_en     = 1'($urandom);
    par_typ    = 1'($urandom);
    prescale   = 6'($urandom);
  endtask

  task automatic pulse_junk();
    p_data     = 8'($urandom);
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy === 1'b0 && !in_frame && exp_q.size() == 0) return;
    end
    fail_now("wait_idle_timeout");
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy === lvl) return;
    end
    fail_now("wait_busy_timeout");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    step();

    // even parity, with an ignored request part way through
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    repeat (30) step();
    p_data     = 8'hFF;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    wait_idle(2000);

    // odd parity
    send(8'hA5, 1'b1, 1'b1, 6'd8);
    wait_idle(2000);

    // no parity, minimum prescale
    send(8'h00, 1'b0, 1'b0, 6'd1);
    wait_idle(2000);

    // back-to-back with data_valid held
    p_data     = 8'h55;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd4;
    data_valid = 1'b1;
    wait_busy(1'b1, 50);
    p_data = 8'h0F;
    wait_busy(1'b0, 200);
    wait_busy(1'b1, 50);
    data_valid = 1'b0;
    wait_idle(2000);

    // prescale 0 runs as 1
    send(8'h3C, 1'b1, 1'b0, 6'd0);
    wait_idle(2000);

    // reset during data bit 3 (busy cycles 16..19 at prescale 4)
    send(8'hC6, 1'b1, 1'b1, 6'd4);
    repeat (16) @(negedge clk);
    #1;
    check("busy_before_rst", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_now_tx_out", 32'(tx_out), 32'd1);
    check("rst_now_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    step();
    send(8'h96, 1'b1, 1'b0, 6'd3);
    wait_idle(2000);

    // randomised frames, some with stray requests
    for (int n = 0; n < 25; n++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 12)) step();
        pulse_junk();
      end
      wait_idle(3000);
      repeat ($urandom_range(0, 3)) step();
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
